pixel_readout: RTL and testbench
================================

Name: pixel_readout

Overview:
- Sits directly downstream of the pixel sequencing FSM.
- Consumes its convert/read1/read2 strobes and drives the ADC ramp code onto the pixel array during CONVERT.
- Captures each row's pixel codes when READ1/READ2 ends, buffers one frame (N_ROW x N_COL), and streams the pixels out over a valid/ready interface with back-pressure and overrun detection.

Parameters:
- DW, 8, pixel/ramp code width in bits
- N_COL, 2, pixels per row (columns on the shared data bus)
- N_ROW, 2, rows per frame (fixed to match read1/read2; only 2 supported)
- RAMP_MAX, 255, saturation value of the ramp code

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- convert  in  1  CONVERT-phase strobe from the sequencing FSM
- read1  in  1  row-0 read strobe
- read2  in  1  row-1 read strobe
- pix_bus  in  N_COL*DW  column data bus from the pixel array; column c at bits [c*DW +: DW]
- ramp_code  out  DW  ADC ramp value driven to the pixel comparators
- out_data  out  DW  streamed pixel code
- out_row  out  1  row index of out_data
- out_col  out  $clog2(N_COL)  column index of out_data
- out_valid  out  1  out_data/out_row/out_col valid
- out_ready  in  1  consumer accepts this cycle
- frame_done  out  1  one-cycle pulse on acceptance of the last pixel of a frame
- overrun  out  1  sticky; a row capture was dropped

Behaviour:
- Reset: synchronous; all outputs 0, buffer valid bits cleared, stream index 0, edge-detect registers 0. Reset mid-frame discards buffered data.
- Edge detect: convert_q, read1_q, read2_q are the inputs registered each posedge.
- Ramp:
  - Cycle with convert=1 and convert_q=0: ramp_code <= 0.
  - Subsequent cycles with convert=1: ramp_code <= ramp_code+1, saturating at RAMP_MAX. No wrap.
  - convert=0: ramp_code <= 0.
  - 255 cycles of convert give codes 0..254; more cycles hold at 255.
- Capture:
  - While readN=1, bus_q <= pix_bus every cycle.
  - Falling edge (readN=0, readN_q=1) writes bus_q (last sampled value during the strobe) into row N-1 and sets that row's N_COL valid bits.
  - The data at the falling-edge cycle itself is not used.
- Drop rule: if any valid bit of the target row is still set at the falling edge, the write is dropped (old data kept) and overrun <= 1 until reset.
- Simultaneous falling edges of read1 and read2: row 0 written; row 1 dropped; overrun set.
- Stream FSM states:
  - WAIT: out_valid=0 until the entry at the current index (row,col) is valid → SEND.
  - SEND: out_valid=1, outputs driven from the buffer entry.
  - Handshake (out_valid & out_ready): clear the entry's valid bit, advance the index col-first (r0c0, r0c1, r1c0, r1c1), wrap to 0 after the last index, return to WAIT or stay in SEND if the next entry is already valid.
- Latency: an entry written at edge k gives out_valid=1 in the cycle after edge k, provided it is the current index.
- Back-to-back valid entries stream at 1 pixel per cycle under constant ready.
- Valid/ready rules:
  - out_valid does not depend on out_ready.
  - Once asserted, out_valid and its data stay stable until the handshake.
  - out_ready=1 with out_valid=0 has no effect.
- frame_done: registered one-cycle pulse in the cycle after the handshake of index N_ROW*N_COL-1.
- Streaming row 0 proceeds while row 1 is still converting/reading. A new row-0 capture is accepted once its entries have been consumed, even if row 1 is still pending.

Decomposition:
- Shared package pixel_pkg holds: DW, N_COL, N_ROW, RAMP_MAX localparams; the stream state enum (WAIT, SEND); the pixel index struct {row, col}. The sequencing FSM and this block import it.
- One natural sub-module: ramp_gen (convert edge detect plus saturating counter, outputs ramp_code).
- Capture buffer and stream FSM stay in pixel_readout.

Test Plan:
- convert high for 255 cycles → ramp_code 0,1,…,254 on consecutive cycles, then 0 after convert falls. Convert held 300 cycles → saturates at 255.
- read1 for 5 cycles with pix_bus={8'hA5,8'h3C}, out_ready=1 → out_valid the cycle after the read1 falling edge. Stream is 8'h3C (r0c0) then 8'hA5 (r0c1), 1 per cycle.
- Full frame {row0=11,22; row1=33,44} with out_ready=1 → stream 11,22,33,44 in order; frame_done pulses once, the cycle after accepting 44.
- out_ready held 0 for 20 cycles after row 0 is captured → out_valid=1 and out_data=r0c0 held stable throughout. Release ready → order preserved.
- With out_ready=0, capture row 0, then a second read1 with different data → overrun=1, original row-0 data still streams; overrun stays 1 until reset.
- Assert reset for 1 cycle mid-stream after r0c0 is accepted → all outputs 0, stream restarts at r0c0 on the next frame, overrun cleared.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel readout path and the sequencing FSM.
package pixel_pkg;

    localparam int DW       = 8;
    localparam int N_COL    = 2;
    localparam int N_ROW    = 2;
    localparam int RAMP_MAX = 255;
    localparam int COL_W    = (N_COL > 1) ? $clog2(N_COL) : 1;

    typedef enum logic {
        WAIT = 1'b0,
        SEND = 1'b1
    } stream_state_t;

    typedef struct packed {
        logic             row;
        logic [COL_W-1:0] col;
    } pix_idx_t;

endpackage

// File: rtl/pixel_readout_ramp_gen.sv
// ADC ramp generator: restarts at 0 on each CONVERT rising edge, climbs by one
// per cycle and saturates at RAMP_MAX; idles at 0 outside CONVERT.
module ramp_gen
    import pixel_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          convert,
    output logic [DW-1:0] ramp_code
);

    logic convert_q;

    // Edge-detect register plus saturating ramp counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            convert_q <= 1'b0;
            ramp_code <= '0;
        end else begin
            convert_q <= convert;
            if (convert && !convert_q)
                ramp_code <= '0;
            else if (convert)
                ramp_code <= (ramp_code == DW'(RAMP_MAX)) ? ramp_code : ramp_code + 1'b1;
            else
                ramp_code <= '0;
        end
    end

endmodule

// File: rtl/pixel_readout.sv
// Pixel readout: drives the ramp, captures each row on the falling edge of its
// read strobe into a one-frame buffer and streams pixels over valid/ready.
module pixel_readout
    import pixel_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  convert,
    input  logic                  read1,
    input  logic                  read2,
    input  logic [N_COL*DW-1:0]   pix_bus,
    output logic [DW-1:0]         ramp_code,
    output logic [DW-1:0]         out_data,
    output logic                  out_row,
    output logic [COL_W-1:0]      out_col,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  overrun
);

    logic [N_ROW-1:0]               rd, rd_q, fall, wr, drop;
    logic [N_ROW-1:0][N_COL*DW-1:0] bus_q, mem, mem_nxt;
    logic [N_ROW-1:0][N_COL-1:0]    vld, vld_nxt;
    logic                           lower_fall;
    stream_state_t                  state;
    pix_idx_t                       idx, nidx;
    logic                           hs, last;

    ramp_gen u_ramp (
        .clk       (clk),
        .reset     (reset),
        .convert   (convert),
        .ramp_code (ramp_code)
    );

    assign rd   = {read2, read1};
    assign fall = ~rd & rd_q;
    assign hs   = out_valid & out_ready;
    assign last = (idx.row == 1'(N_ROW-1)) && (idx.col == COL_W'(N_COL-1));

    // Decide which falling edges write; a row still holding unconsumed pixels,
    // or a higher row falling together with a lower one, is dropped.
    always_comb begin
        wr         = '0;
        drop       = '0;
        lower_fall = 1'b0;
        for (int r = 0; r < N_ROW; r++) begin
            if (fall[r]) begin
                if ((|vld[r]) || lower_fall)
                    drop[r] = 1'b1;
                else
                    wr[r] = 1'b1;
                lower_fall = 1'b1;
            end
        end
    end

    // Next buffer contents; the stream FSM looks at these so a fresh write is
    // presented the cycle right after it lands.
    always_comb begin
        vld_nxt = vld;
        mem_nxt = mem;
        if (hs)
            vld_nxt[idx.row][idx.col] = 1'b0;
        for (int r = 0; r < N_ROW; r++) begin
            if (wr[r]) begin
                vld_nxt[r] = '1;
                mem_nxt[r] = bus_q[r];
            end
        end
    end

    // Column-first stream index advance with wrap after the last pixel.
    always_comb begin
        nidx = idx;
        if (idx.col == COL_W'(N_COL-1)) begin
            nidx.col = '0;
            nidx.row = last ? 1'b0 : idx.row + 1'b1;
        end else begin
            nidx.col = idx.col + 1'b1;
        end
    end

    // Strobe sampling, frame buffer storage and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q    <= '0;
            bus_q   <= '0;
            vld     <= '0;
            mem     <= '0;
            overrun <= 1'b0;
        end else begin
            rd_q <= rd;
            for (int r = 0; r < N_ROW; r++)
                if (rd[r]) bus_q[r] <= pix_bus;
            vld <= vld_nxt;
            mem <= mem_nxt;
            if (|drop) overrun <= 1'b1;
        end
    end

    // Stream FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= WAIT;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= 1'b0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= hs & last;
            case (state)
                WAIT: begin
                    if (vld_nxt[idx.row][idx.col]) begin
                        state     <= SEND;
                        out_valid <= 1'b1;
                        out_data  <= mem_nxt[idx.row][int'(idx.col)*DW +: DW];
                        out_row   <= idx.row;
                        out_col   <= idx.col;
                    end
                end
                SEND: begin
                    if (hs) begin
                        idx <= nidx;
                        if (vld_nxt[nidx.row][nidx.col]) begin
                            out_data <= mem_nxt[nidx.row][int'(nidx.col)*DW +: DW];
                            out_row  <= nidx.row;
                            out_col  <= nidx.col;
                        end else begin
                            state     <= WAIT;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: ramp, capture, streaming, back-pressure,
// overrun and mid-stream reset.
module tb_pixel_readout;
    import pixel_pkg::*;

    logic                clk = 1'b0;
    logic                reset, convert, read1, read2, out_ready;
    logic [N_COL*DW-1:0] pix_bus;
    logic [DW-1:0]       ramp_code, out_data;
    logic                out_row, out_valid, frame_done, overrun;
    logic [COL_W-1:0]    out_col;

    int errors = 0;
    int checks = 0;

    pixel_readout dut (
        .clk        (clk),
        .reset      (reset),
        .convert    (convert),
        .read1      (read1),
        .read2      (read2),
        .pix_bus    (pix_bus),
        .ramp_code  (ramp_code),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_col    (out_col),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Hold the selected strobes for n cycles on bus, then drop them with junk on the bus.
    task automatic do_read(input logic r1, input logic r2, input logic [15:0] bus, input int n);
        read1   = r1;
        read2   = r2;
        pix_bus = bus;
        repeat (n) tick();
        read1   = 1'b0;
        read2   = 1'b0;
        pix_bus = 16'hFFFF;
    endtask

    task automatic chk_pix(input string tag, input logic [7:0] d, input logic r, input logic c);
        chk({tag, "_v"}, out_valid, 1);
        chk({tag, "_d"}, out_data, d);
        chk({tag, "_r"}, out_row, r);
        chk({tag, "_c"}, out_col, c);
    endtask

    initial begin
        reset = 1'b1; convert = 1'b0; read1 = 1'b0; read2 = 1'b0;
        out_ready = 1'b0; pix_bus = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ramp", ramp_code, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_ovr", overrun, 0);

        // Ramp: 255 cycles -> 0..254, then back to 0; 300 cycles saturates at 255.
        convert = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick();
            chk("ramp", ramp_code, i);
        end
        convert = 1'b0;
        tick();
        chk("ramp_off", ramp_code, 0);
        convert = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            chk("ramp_sat", ramp_code, (i > 255) ? 255 : i);
        end
        convert = 1'b0;
        tick();
        chk("ramp_off2", ramp_code, 0);

        // Row 0 capture; bus value on the falling-edge cycle must be ignored.
        out_ready = 1'b1;
        read1 = 1'b1; pix_bus = 16'hA53C;
        repeat (5) begin
            tick();
            chk("r0_idle", out_valid, 0);
        end
        read1 = 1'b0; pix_bus = 16'hFFFF;
        tick();
        chk_pix("r0c0", 8'h3C, 0, 0);
        tick();
        chk_pix("r0c1", 8'hA5, 0, 1);
        tick();
        chk("r0_end", out_valid, 0);

        // Full frame with frame_done pulse.
        do_reset();
        do_read(1, 0, 16'h2211, 3);
        tick(); chk_pix("f_r0c0", 8'h11, 0, 0);
        tick(); chk_pix("f_r0c1", 8'h22, 0, 1);
        tick(); chk("f_gap", out_valid, 0);
        do_read(0, 1, 16'h4433, 3);
        tick(); chk_pix("f_r1c0", 8'h33, 1, 0);
        chk("f_fd0", frame_done, 0);
        tick(); chk_pix("f_r1c1", 8'h44, 1, 1);
        chk("f_fd1", frame_done, 0);
        tick();
        chk("f_fd", frame_done, 1);
        chk("f_end", out_valid, 0);
        tick();
        chk("f_fd_off", frame_done, 0);

        // Back-pressure: held stable for 20 cycles, then order preserved.
        out_ready = 1'b0;
        do_read(1, 0, 16'hBBAA, 2);
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_pix("bp_hold", 8'hAA, 0, 0);
        end
        out_ready = 1'b1;
        tick(); chk_pix("bp_c1", 8'hBB, 0, 1);
        tick(); chk("bp_end", out_valid, 0);

        // Overrun: second row-0 capture while row 0 still unconsumed.
        do_reset();
        out_ready = 1'b0;
        do_read(1, 0, 16'h0201, 2);
        tick(); chk_pix("ov_first", 8'h01, 0, 0);
        chk("ov_clear", overrun, 0);
        do_read(1, 0, 16'hF2F1, 2);
        tick();
        chk("ov_set", overrun, 1);
        chk_pix("ov_keep", 8'h01, 0, 0);
        out_ready = 1'b1;
        tick(); chk_pix("ov_c1", 8'h02, 0, 1);
        tick(); chk("ov_end", out_valid, 0);
        do_read(0, 1, 16'h7877, 2);
        tick(); chk_pix("ov_r1c0", 8'h77, 1, 0);
        tick(); chk_pix("ov_r1c1", 8'h78, 1, 1);
        tick(); chk("ov_fd", frame_done, 1);
        chk("ov_sticky", overrun, 1);

        // Reset after r0c0 accepted: discards r0c1, clears overrun.
        do_read(1, 0, 16'h6655, 2);
        tick(); chk_pix("mr_c0", 8'h55, 0, 0);
        tick(); chk_pix("mr_c1", 8'h66, 0, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_col", out_col, 0);
        chk("mr_ovr", overrun, 0);
        chk("mr_fd", frame_done, 0);
        do_read(1, 0, 16'h9988, 2);
        tick(); chk_pix("mr_new", 8'h88, 0, 0);
        chk("mr_ovr2", overrun, 0);
        tick(); chk_pix("mr_new1", 8'h99, 0, 1);
        tick(); chk("mr_end", out_valid, 0);

        // Simultaneous falling edges: row 0 kept, row 1 dropped.
        do_reset();
        out_ready = 1'b0;
        do_read(1, 1, 16'hD2D1, 2);
        tick();
        chk_pix("sim_c0", 8'hD1, 0, 0);
        chk("sim_ovr", overrun, 1);
        out_ready = 1'b1;
        tick(); chk_pix("sim_c1", 8'hD2, 0, 1);
        tick(); chk("sim_r1_none", out_valid, 0);
        tick(); chk("sim_r1_none2", out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
